// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage (state encoding, register index width, bubble values).
package mem_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Control half of a MEM/WB entry; the data half of a bubble is BUBBLE_DATA.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
    } wb_ctl_t;

    localparam wb_ctl_t        BUBBLE_CTL  = '0;
    localparam logic [63:0]    BUBBLE_DATA = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: each cycle loads either the stage result or a bubble.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_result,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [REG_IDX_W-1:0] rd_in,
    input  logic                 regwrite_in,
    output logic [DATA_W-1:0]    wb_data,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic                 wb_regwrite
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data     <= DATA_W'(BUBBLE_DATA);
            wb_rd       <= BUBBLE_CTL.rd;
            wb_regwrite <= BUBBLE_CTL.regwrite;
        end else if (load_result) begin
            wb_data     <= data_in;
            wb_rd       <= rd_in;
            wb_regwrite <= regwrite_in;
        end else begin
            wb_data     <= DATA_W'(BUBBLE_DATA);
            wb_rd       <= BUBBLE_CTL.rd;
            wb_regwrite <= BUBBLE_CTL.regwrite;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, stalls upstream until ack.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses are dropped and flagged via misalign_fault.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    alu_in,
    input  logic [DATA_W-1:0]    wdata_in,
    input  logic [REG_IDX_W-1:0] rd_in,
    input  logic                 RegWrite_in,
    input  logic                 MemRead_in,
    input  logic                 MemWrite_in,
    input  logic                 MemToReg_in,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 stall,
    output logic [DATA_W-1:0]    wb_data,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic                 wb_RegWrite,
    output logic                 misalign_fault
);

    state_t              state;
    state_t              next_state;
    logic                mem_op_c;
    logic                misalign_c;
    logic                issue_c;
    logic                wb_load_c;
    logic                fault_c;
    logic [DATA_W-1:0]   wb_result_c;

    assign mem_op_c = MemRead_in | MemWrite_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = (alu_in[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, stall and MEM/WB load decision.
    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        issue_c     = 1'b0;
        wb_load_c   = 1'b0;
        fault_c     = 1'b0;
        wb_result_c = alu_in;
        unique case (state)
            IDLE: begin
                if (mem_op_c) begin
                    if (misalign_c) begin
                        fault_c = 1'b1;
                    end else begin
                        issue_c    = 1'b1;
                        stall      = 1'b1;
                        next_state = BUSY;
                    end
                end else begin
                    wb_load_c = 1'b1;
                end
            end
            BUSY: begin
                stall = !dmem_ack;
                if (dmem_ack) begin
                    wb_load_c   = 1'b1;
                    wb_result_c = MemToReg_in ? dmem_rdata : alu_in;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request registers stay frozen for the whole BUSY period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            misalign_fault <= 1'b0;
        end else begin
            misalign_fault <= fault_c;
            if (issue_c) begin
                dmem_req   <= 1'b1;
                dmem_we    <= MemWrite_in;
                dmem_addr  <= ADDR_W'(alu_in);
                dmem_wdata <= wdata_in;
            end else if ((state == BUSY) && dmem_ack) begin
                dmem_req   <= 1'b0;
            end
        end
    end

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk         (clk),
        .reset       (reset),
        .load_result (wb_load_c),
        .data_in     (wb_result_c),
        .rd_in       (rd_in),
        .regwrite_in (RegWrite_in),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_RegWrite)
    );

endmodule
